// File: rtl/count_display_driver_pkg.sv
// Shared constants for the count/tally display driver: hex-to-segment table
// and the all-off patterns for segments and anodes.
package count_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [1:0] AN_OFF    = 2'b11;

   // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n.
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/count_display_driver_if.sv
// Counter input and display outputs of the count display driver.
interface count_display_driver_if;

   logic [3:0] count;
   logic [6:0] seg;
   logic [1:0] an;
   logic       wrap_pulse;

   modport master (output count, input seg, an, wrap_pulse);
   modport slave  (input count, output seg, an, wrap_pulse);

endinterface

// File: rtl/count_display_driver_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment glyph lookup.
module hex_to_seg7
   import count_disp_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = HEX7_TABLE[hex];

endmodule

// File: rtl/count_display_driver.sv
// Tracks 15->0 wraps of an upstream counter and scans count (digit 0) and
// wrap tally (digit 1) onto a 2-digit common-anode 7-segment display.
//
// state  | meaning
// DIG_LO | digit 0 lit, showing the frame-latched count
// DIG_HI | digit 1 lit, showing the frame-latched wrap tally
module count_display_driver
   import count_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 4,
   parameter bit BLANK_HI    = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   count_display_driver_if.slave bus
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   localparam logic [0:0] DIG_LO = 1'b0;
   localparam logic [0:0] DIG_HI = 1'b1;

   logic [3:0]       prev_q,    prev_d;
   logic [3:0]       tally_q,   tally_d;
   logic             wrap_q,    wrap_d;
   logic [DIV_W-1:0] div_q,     div_d;
   logic [0:0]       sel_q,     sel_d;
   logic [3:0]       disp_lo_q, disp_lo_d;
   logic [3:0]       disp_hi_q, disp_hi_d;
   logic [6:0]       seg_q,     seg_d;
   logic [1:0]       an_q,      an_d;

   logic             wrap_evt;
   logic             clr_evt;
   logic             frame_tick;
   logic [3:0]       hex_sel;
   logic [6:0]       seg_hex;

   assign hex_sel = (sel_q == DIG_HI) ? disp_hi_q : disp_lo_q;

   hex_to_seg7 u_hex_to_seg7 (
      .hex (hex_sel),
      .seg (seg_hex)
   );

   always_comb begin
      wrap_evt   = (prev_q == 4'hF) && (bus.count == 4'h0);
      // A drop to 0 from anywhere but 15 (or 0) is the upstream counter being reset.
      clr_evt    = (bus.count == 4'h0) && (prev_q != 4'h0) && (prev_q != 4'hF);
      frame_tick = (div_q == DIV_LAST);

      prev_d  = bus.count;
      wrap_d  = wrap_evt;
      tally_d = tally_q;
      if (wrap_evt) begin
         tally_d = tally_q + 4'd1;
      end else if (clr_evt) begin
         tally_d = 4'h0;
      end

      div_d = frame_tick ? '0 : div_q + DIV_W'(1);
      sel_d = frame_tick ? ~sel_q : sel_q;

      // Latch at end of frame so a digit never changes while lit; takes the pre-update tally.
      disp_lo_d = disp_lo_q;
      disp_hi_d = disp_hi_q;
      if (frame_tick && (sel_q == DIG_HI)) begin
         disp_lo_d = bus.count;
         disp_hi_d = tally_q;
      end

      an_d  = (sel_q == DIG_LO) ? 2'b10 : 2'b01;
      seg_d = seg_hex;
      if (BLANK_HI && (sel_q == DIG_HI) && (disp_hi_q == 4'h0)) begin
         seg_d = SEG_BLANK;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q    <= 4'h0;
         tally_q   <= 4'h0;
         wrap_q    <= 1'b0;
         div_q     <= '0;
         sel_q     <= DIG_LO;
         disp_lo_q <= 4'h0;
         disp_hi_q <= 4'h0;
         seg_q     <= SEG_BLANK;
         an_q      <= AN_OFF;
      end else begin
         prev_q    <= prev_d;
         tally_q   <= tally_d;
         wrap_q    <= wrap_d;
         div_q     <= div_d;
         sel_q     <= sel_d;
         disp_lo_q <= disp_lo_d;
         disp_hi_q <= disp_hi_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: each stimulus cycle pushes the
// expected {an,seg,wrap_pulse}; a monitor pops and compares every cycle.
module tb_count_display_driver;

   localparam int DIV = 4;

   logic clk;
   logic reset;

   count_display_driver_if bus ();

   count_display_driver #(.REFRESH_DIV(DIV), .BLANK_HI(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int checks = 0;
   int errors = 0;
   int wrap_seen = 0;

   logic [9:0] sb [$];

   // Reference: edge k (1-based since reset release) shows digit ((k-1)/DIV)%2
   // with the values latched at the last frame boundary (k multiple of 2*DIV).
   int         m_k;
   logic [3:0] m_prev, m_tally, m_lo, m_hi;

   task automatic model_reset();
      m_k = 0; m_prev = 4'h0; m_tally = 4'h0; m_lo = 4'h0; m_hi = 4'h0;
   endtask

   task automatic step(input logic [3:0] c);
      logic [1:0] e_an;
      logic [6:0] e_seg;
      logic       e_wrap;
      logic       digit1;
      bus.count = c;
      @(posedge clk);
      m_k++;
      digit1 = (((m_k - 1) / DIV) % 2) == 1;
      e_an   = digit1 ? 2'b01 : 2'b10;
      e_seg  = digit1 ? ((m_hi == 4'h0) ? 7'h7F : HEX[m_hi]) : HEX[m_lo];
      e_wrap = (m_prev == 4'hF) && (c == 4'h0);
      if ((m_k % (2 * DIV)) == 0) begin
         m_lo = c;
         m_hi = m_tally;
      end
      if (e_wrap) m_tally = m_tally + 4'd1;
      else if (c == 4'h0 && m_prev != 4'h0 && m_prev != 4'hF) m_tally = 4'h0;
      m_prev = c;
      sb.push_back({e_an, e_seg, e_wrap});
      @(negedge clk);
   endtask

   task automatic hold(input logic [3:0] c, input int n);
      for (int i = 0; i < n; i++) step(c);
   endtask

   task automatic full_wrap();
      for (int v = 1; v <= 16; v++) step(4'(v));
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Monitor: one DUT output word per clock while expectations are pending.
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (!reset && bus.wrap_pulse) wrap_seen++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.wrap_pulse} != e) begin
               errors++;
               $display("FAIL scan t=%0t an=%b/%b seg=%h/%h wrap=%b/%b", $time,
                        bus.an, e[9:8], bus.seg, e[7:1], bus.wrap_pulse, e[0]);
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      bus.count = 4'h0;
      #1;
      check_val("reset_seg", int'(bus.seg), 'h7F);
      check_val("reset_an", int'(bus.an), 'h3);
      check_val("reset_wrap", int'(bus.wrap_pulse), 0);
      repeat (3) @(posedge clk);
      release_reset();

      // 1: idle scan with count held at 0
      hold(4'h0, 16);

      // 2: single wrap, then let digit 1 show the new tally
      full_wrap();
      hold(4'h0, 16);

      // 3: 15 more wraps, tally rolls over to 0 and digit 1 blanks
      for (int w = 0; w < 15; w++) full_wrap();
      hold(4'h0, 16);
      #1;
      check_val("wraps_after_rollover", wrap_seen, 16);

      // 4: tally 3, then upstream clear 7 -> 0
      for (int w = 0; w < 3; w++) full_wrap();
      for (int v = 1; v <= 7; v++) step(4'(v));
      step(4'h0);
      hold(4'h0, 16);
      #1;
      check_val("wraps_after_clear", wrap_seen, 19);

      // 5: count changing every cycle; digit 0 must hold the frame-latched value
      for (int i = 0; i < 24; i++) step(4'(i * 3));
      hold(4'h0, 8);

      // 6: tally 5, async reset between edges in mid-frame
      for (int w = 0; w < 5; w++) full_wrap();
      step(4'h1);
      step(4'h2);
      #1;
      check_val("wraps_before_reset", wrap_seen, 24);
      #1;
      reset = 1'b1;
      #1;
      check_val("async_seg", int'(bus.seg), 'h7F);
      check_val("async_an", int'(bus.an), 'h3);
      check_val("async_wrap", int'(bus.wrap_pulse), 0);
      bus.count = 4'h0;
      repeat (2) @(posedge clk);
      release_reset();
      hold(4'h0, 16);

      for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
Downstream consumer of the 4-bit free-running counter. Tracks the counter's 15->0 wraps in a 4-bit wrap tally and shows both values on a 2-digit multiplexed common-anode 7-segment display: digit 0 shows the live count in hex, digit 1 shows the wrap tally in hex. Display values are latched once per scan frame, so a digit never changes while it is lit. It also emits a one-cycle wrap strobe for other consumers.

Parameters:
REFRESH_DIV, 4, clock cycles each digit stays enabled; legal range >= 2.
BLANK_HI, 1, when 1, digit 1 is blanked while its latched tally is 0 (leading-zero suppression).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
count  input  4  counter value, sampled every clk.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
an  output  2  digit anodes, active-low; an[0]=digit 0 (count), an[1]=digit 1 (tally); registered.
wrap_pulse  output  1  one-cycle strobe per detected 15->0 wrap, registered.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-high: asserting reset clears all state immediately, with no clock edge required.
- Values while reset is high: seg=7'h7F, an=2'b11, wrap_pulse=0, prev=0, tally=0, div_cnt=0, digit_sel=0, disp_lo=0, disp_hi=0.
- prev register: prev<=count on every clk edge.
- Wrap detection (combinational):
  - wrap_evt = (prev==4'hF && count==4'h0).
  - clr_evt = (count==0 && prev!=0 && prev!=4'hF). This is the upstream counter being reset mid-run.
- On the edge where wrap_evt holds:
  - tally<=tally+1, modulo 16 (4'hF+1 -> 4'h0; no saturation).
  - wrap_pulse<=1.
  - Result: wrap_pulse is high for exactly the one cycle following the first cycle count reads 0.
- On the edge where clr_evt holds: tally<=0, and wrap_pulse stays 0.
- wrap_evt and clr_evt are mutually exclusive by construction. A count held at 0 (prev==0) triggers neither.
- Scan prescaler:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the edge where div_cnt==REFRESH_DIV-1, digit_sel toggles.
- Frame latch:
  - On the edge where div_cnt==REFRESH_DIV-1 and digit_sel==1 (end of frame), disp_lo<=count and disp_hi<=tally.
  - If an event updates tally on that same edge, disp_hi takes the old tally; the new value appears next frame.
- Output stage (registered, 1-cycle latency from digit_sel/disp):
  - an<=(digit_sel==0)?2'b10:2'b01.
  - seg<=hex7(digit_sel?disp_hi:disp_lo).
  - If BLANK_HI==1, digit_sel==1 and disp_hi==0, then seg<=7'h7F while an[1] is still driven low.
- Resulting timing: each anode is low for exactly REFRESH_DIV consecutive cycles and exactly one anode is low at any time after the first post-reset edge.
- hex7 table (active-low, gfedcba):
  - 0:40 1:79 2:24 3:30
  - 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03
  - C:46 d:21 E:06 F:0E
- Reset mid-frame: everything returns to reset values asynchronously. After deassertion, the scan restarts at digit 0 with div_cnt=0.
- Unknown or X count: not required to be handled.

Decomposition:
- Shared package count_disp_pkg holds:
  - the 16-entry hex-to-seg7 constant table,
  - SEG_BLANK=7'h7F,
  - AN_OFF=2'b11.
- One combinational sub-module, hex_to_seg7 (4-bit in, 7-bit out), reads the package table. All registers stay in count_display_driver.

Test Plan:
1. Reset scan: REFRESH_DIV=4, reset high then released, count held at 0 -> an sequence 10,10,10,10,01,01,01,01 repeating; seg=40 on digit 0; seg=7F on digit 1 (blanked); wrap_pulse never high.
2. Single wrap: count steps 0..F then 0 once per clk -> wrap_pulse high for exactly 1 cycle, the cycle after count==0; tally=1; after the next frame boundary digit 1 shows seg=79.
3. Tally rollover: 16 full counter wraps -> 16 wrap_pulse strobes; tally returns to 0; digit 1 blanked again.
4. Upstream clear: tally=3, count jumps 7->0 -> no wrap_pulse; tally=0; next frame digit 1 blanked, digit 0 shows 40.
5. Frame-stable latch: count changes every cycle during digit 0's window -> seg for digit 0 stays constant across its 4 lit cycles and equals the count sampled at the previous frame boundary.
6. Async reset mid-frame: assert reset between clk edges with tally=5 -> seg=7F, an=11, wrap_pulse=0 immediately without a clk edge; after release the scan restarts at digit 0.
